// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte sources (round-robin) with a tx_done watchdog.
// Define UART_ARB_PRIORITY_EN for fixed lowest-index-first priority instead of round-robin.
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [7:0]               uart_data,
  output logic                     uart_start,
  input  logic                     uart_done,
  output logic                     timeout_err,
  output logic [$clog2(N_REQ)-1:0] err_chan
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    winner;
  logic [7:0]       sel_data;
  logic [7:0]       data_nxt;
  logic [IW-1:0]    grant_nxt, echan_nxt;
  logic [N_REQ-1:0] ack_nxt, done_nxt;
  logic             start_nxt, terr_nxt, finish;
  logic [WW-1:0]    wd_cnt, wd_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;

`ifdef UART_ARB_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end
`else
  logic [IW-1:0] rr;
  int unsigned   idx;
  logic          found;

  // Search starts one past the last served channel and wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(rr) + i) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr <= IW'(N_REQ - 1);
    else if (finish) rr <= grant_id;
  end
`endif

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IW'(k) == winner) sel_data = req_data[8*k +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = uart_data;
    grant_nxt = grant_id;
    ack_nxt   = '0;
    done_nxt  = '0;
    start_nxt = 1'b0;
    terr_nxt  = timeout_err;
    echan_nxt = err_chan;
    wd_nxt    = wd_cnt;
    gap_nxt   = gap_cnt;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = START;
          data_nxt  = sel_data;
          grant_nxt = winner;
          start_nxt = 1'b1;
          ack_nxt   = ONE << winner;
        end
      end
      START: begin
        wd_nxt    = '0;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A completion coinciding with expiry counts as a completion.
        if (uart_done) begin
          done_nxt = ONE << grant_id;
          finish   = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          terr_nxt  = 1'b1;
          echan_nxt = grant_id;
          finish    = 1'b1;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
        if (finish) begin
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
          gap_nxt   = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      uart_data   <= '0;
      grant_id    <= '0;
      ack         <= '0;
      done        <= '0;
      uart_start  <= 1'b0;
      timeout_err <= 1'b0;
      err_chan    <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      uart_data   <= data_nxt;
      grant_id    <= grant_nxt;
      ack         <= ack_nxt;
      done        <= done_nxt;
      uart_start  <= start_nxt;
      timeout_err <= terr_nxt;
      err_chan    <= echan_nxt;
      wd_cnt      <= wd_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level model of the arbiter compared every cycle, plus directed literal checks.
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 100;
  localparam int GP = 0;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   ack, done;
  logic [1:0]      grant_id, err_chan;
  logic            busy, uart_start, timeout_err;
  logic            uart_done = 1'b0;
  logic [7:0]      uart_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .grant_id(grant_id), .busy(busy),
    .uart_data(uart_data), .uart_start(uart_start), .uart_done(uart_done),
    .timeout_err(timeout_err), .err_chan(err_chan)
  );

  int checks = 0;
  int errors = 0;

  // Per-channel byte queues feeding the requesters.
  logic [7:0] qmem [NR][16];
  int qh [NR];
  int qt [NR];

  logic [7:0] sent[$];
  int glog[$];
  int slog[$];
  int done_cnt [NR];
  int tick_n = 0;
  int cd = 0;
  int tx_delay = 2;
  bit extra_done = 1'b0;
  bit rst_knob = 1'b0;
  int t_udone = -1, t_done = -1, t_terr = -1;
  logic [NR-1:0] start_ack = '0;

  // Model: one byte owns the UART from its grant edge until done/timeout.
  bit m_own = 1'b0;
  int m_age = 0;
  int m_gap = 0;
  int m_rr  = NR - 1;
  logic [NR-1:0] e_ack = '0, e_done = '0;
  logic e_start = 1'b0, e_busy = 1'b0, e_terr = 1'b0;
  logic [1:0] e_grant = '0, e_echan = '0;
  logic [7:0] e_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [NR-1:0] r, int rr);
`ifdef UART_ARB_PRIORITY_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int i = 1; i <= NR; i++) if (r[(rr + i) % NR]) return (rr + i) % NR;
`endif
    return 0;
  endfunction

  function automatic logic [7:0] sent_at(int i);
    return (i < sent.size()) ? sent[i] : 8'hxx;
  endfunction

  function automatic int glog_at(int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  task automatic model_step();
    int w;
    e_ack   = '0;
    e_done  = '0;
    e_start = 1'b0;
    if (!reset) begin
      m_own = 1'b0; m_gap = 0; m_rr = NR - 1;
      e_grant = '0; e_data = '0; e_terr = 1'b0; e_echan = '0;
    end else if (m_own) begin
      m_age++;
      if (m_age >= 2) begin
        // m_age-1 waiting cycles have elapsed when this edge lands.
        if (uart_done) begin
          e_done = 4'b0001 << e_grant;
          m_rr = int'(e_grant); m_own = 1'b0; m_gap = GP;
        end else if (m_age - 1 == TO) begin
          e_terr = 1'b1; e_echan = e_grant;
          m_rr = int'(e_grant); m_own = 1'b0; m_gap = GP;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
      w = pick(req, m_rr);
      m_own = 1'b1; m_age = 0;
      e_start = 1'b1;
      e_ack   = 4'b0001 << w;
      e_grant = 2'(w);
      e_data  = req_data[8*w +: 8];
    end
    e_busy = m_own || (m_gap > 0);
  endtask

  task automatic tick();
    @(negedge clk);
    tick_n++;
    check("ack",         32'(ack),         32'(e_ack));
    check("done",        32'(done),        32'(e_done));
    check("uart_start",  32'(uart_start),  32'(e_start));
    check("busy",        32'(busy),        32'(e_busy));
    check("grant_id",    32'(grant_id),    32'(e_grant));
    check("uart_data",   32'(uart_data),   32'(e_data));
    check("timeout_err", 32'(timeout_err), 32'(e_terr));
    check("err_chan",    32'(err_chan),    32'(e_echan));
    for (int k = 0; k < NR; k++) if (done[k]) begin done_cnt[k]++; t_done = tick_n; end
    if (timeout_err && t_terr < 0) t_terr = tick_n;
    // Serializer stand-in: tx_done tx_delay cycles after the start pulse, 0 = hung.
    uart_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin uart_done = 1'b1; t_udone = tick_n; end
    end
    if (extra_done) begin uart_done = 1'b1; extra_done = 1'b0; end
    if (uart_start) begin
      sent.push_back(uart_data); glog.push_back(int'(grant_id)); slog.push_back(tick_n);
      start_ack = ack; cd = tx_delay;
    end
    reset = rst_knob;
    if (!reset) begin cd = 0; uart_done = 1'b0; end
    // Requesters drop req on ack and raise it again while bytes remain.
    for (int k = 0; k < NR; k++) begin
      if (ack[k] && qh[k] != qt[k]) qh[k]++;
      req[k] = !ack[k] && (qh[k] != qt[k]);
      req_data[8*k +: 8] = (qh[k] != qt[k]) ? qmem[k][qh[k]] : 8'h00;
    end
    model_step();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(int k, logic [7:0] b);
    qmem[k][qt[k]] = b;
    qt[k]++;
  endtask

  task automatic do_reset();
    rst_knob = 1'b0;
    for (int k = 0; k < NR; k++) begin qh[k] = 0; qt[k] = 0; done_cnt[k] = 0; end
    tick();
    tick();
    sent.delete(); glog.delete(); slog.delete();
    t_terr = -1; t_done = -1; t_udone = -1;
    rst_knob = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);

    // All four channels requesting continuously
    tx_delay = 2;
    push(0, 8'h11); push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    run(30);
    check("fair_count", 32'(sent.size()), 32'd5);
`ifdef UART_ARB_PRIORITY_EN
    check("fair_b0", 32'(sent_at(0)), 32'h11); check("fair_b1", 32'(sent_at(1)), 32'h11);
    check("fair_b2", 32'(sent_at(2)), 32'h22); check("fair_b3", 32'(sent_at(3)), 32'h33);
    check("fair_b4", 32'(sent_at(4)), 32'h44);
`else
    check("fair_b0", 32'(sent_at(0)), 32'h11); check("fair_b1", 32'(sent_at(1)), 32'h22);
    check("fair_b2", 32'(sent_at(2)), 32'h33); check("fair_b3", 32'(sent_at(3)), 32'h44);
    check("fair_b4", 32'(sent_at(4)), 32'h11);
    for (int k = 0; k < NR; k++) check("fair_grant", 32'(glog_at(k)), 32'(k));
`endif

    // Single channel
    do_reset();
    tx_delay = 3;
    push(2, 8'hA5);
    run(12);
    check("single_ack_with_start", 32'(start_ack), 32'b0100);
    check("single_grant", 32'(glog_at(0)), 32'd2);
    check("single_data", 32'(sent_at(0)), 32'hA5);
    check("single_done_cnt", 32'(done_cnt[2]), 32'd1);
    check("single_done_lat", 32'(t_done - t_udone), 32'd1);

    // Two channels held: round-robin alternates, priority starves channel 3
    do_reset();
    tx_delay = 2;
    for (int i = 0; i < 4; i++) begin push(1, 8'h10 + 8'(i)); push(3, 8'h30 + 8'(i)); end
    run(40);
`ifdef UART_ARB_PRIORITY_EN
    for (int i = 0; i < 4; i++) check("prio_order", 32'(glog_at(i)), 32'd1);
`else
    check("rr_order0", 32'(glog_at(0)), 32'd1); check("rr_order1", 32'(glog_at(1)), 32'd3);
    check("rr_order2", 32'(glog_at(2)), 32'd1); check("rr_order3", 32'(glog_at(3)), 32'd3);
`endif

    // Hung serializer: watchdog expiry, then the next request is served
    do_reset();
    tx_delay = 0;
    push(1, 8'h99);
    run(5);
    tx_delay = 3;
    push(3, 8'hE7);
    run(120);
    check("to_latency", 32'(t_terr - (slog.size() > 0 ? slog[0] : 0)), 32'(TO + 1));
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_chan", 32'(err_chan), 32'd1);
    check("to_no_done", 32'(done_cnt[1]), 32'd0);
    check("to_next_data", 32'(sent_at(1)), 32'hE7);
    check("to_next_done", 32'(done_cnt[3]), 32'd1);

    // tx_done in IDLE is ignored; tx_done on the expiry cycle wins over the watchdog
    do_reset();
    extra_done = 1'b1;
    run(3);
    check("idle_done_ignored", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'd0);
    tx_delay = TO;
    push(0, 8'hC3);
    run(110);
    check("coinc_done", 32'(done_cnt[0]), 32'd1);
    check("coinc_no_err", 32'(timeout_err), 32'd0);
    check("coinc_done_lat", 32'(t_done - t_udone), 32'd1);

    // Reset during WAIT_DONE of byte 3C
    do_reset();
    tx_delay = 20;
    push(2, 8'h3C); push(3, 8'h5A);
    run(6);
    check("mid_busy", 32'(busy), 32'd1);
    rst_knob = 1'b0;
    tick();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(uart_data), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    tick();
    sent.delete(); glog.delete();
    push(2, 8'h3C);
    rst_knob = 1'b1;
    tx_delay = 3;
    run(20);
    check("mid_regrant", 32'(glog_at(0)), 32'd2);
    check("mid_resend", 32'(sent_at(0)), 32'h3C);
    check("mid_next", 32'(sent_at(1)), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
